// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous flagged FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEPTH     = 16;
  // Almost-full default sits this many entries below DEPTH.
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_THRESH = 2;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width: addresses entries 0..depth-1 (depth >= 2 keeps this >= 1).
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer with increment enable and synchronous reset.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer: advance on enable, wrapping from DEPTH-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) ptr_d = '0;
      else                            ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered read data, occupancy count, level flags
// and sticky overflow/underflow indicators.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data_in,
  input  logic             fifo_write,
  input  logic             fifo_read,
  input  logic             err_clr,
  output logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             fifo_almost_full,
  output logic             fifo_almost_empty,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_overflow,
  output logic             fifo_underflow
);

  localparam int PTR_W = ptr_w(DEPTH);

  // Reject illegal parameterisations at elaboration time.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_out_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ovf_q;
  logic             udf_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic             ovf_set;
  logic             udf_set;

  assign fifo_full         = (count_q == CNT_W'(DEPTH));
  assign fifo_empty        = (count_q == '0);
  assign fifo_almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign fifo_almost_empty = (count_q <= CNT_W'(AE_THRESH));

  // A read frees a slot in the same cycle, so a full FIFO still takes a
  // write when a read is accepted alongside it. An empty FIFO never reads.
  assign rd_acc  = fifo_read && !fifo_empty;
  assign wr_acc  = fifo_write && (!fifo_full || rd_acc);
  assign ovf_set = fifo_write && !wr_acc;
  assign udf_set = fifo_read && fifo_empty;

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_acc),
    .ptr_o (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_acc),
    .ptr_o (rd_ptr)
  );

  // Occupancy: net change of accepted writes minus accepted reads.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents survive reset because pointers/count gate access.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr] <= fifo_data_in;
  end

  // Count, registered read data and sticky error flags (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      count_q <= count_d;
      if (rd_acc) data_out_q <= mem_q[rd_ptr];
      if (ovf_set)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (udf_set)      udf_q <= 1'b1;
      else if (err_clr) udf_q <= 1'b0;
    end
  end

  assign fifo_data_out  = data_out_q;
  assign fifo_count     = count_q;
  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = udf_q;

endmodule
